// File: rtl/sha256_job_sched.sv
// Round-robin scheduler that time-shares one single-block sha256 core among N_REQ requesters.
// One job in flight: grant in IDLE, hold core in reset during LOAD, wait for a fresh ready in RUN, report in DONE.
module sha256_job_sched #(
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int RST_CYCLES = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       blk_valid,
  input  logic [N_REQ*512-1:0]   blk_data,
  output logic [N_REQ-1:0]       blk_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [255:0]           res_hash,
  output logic                   res_err,
  output logic                   core_reset,
  output logic [511:0]           core_data,
  input  logic                   core_ready,
  input  logic [255:0]           core_hash,
  output logic                   busy,
  output logic [15:0]            jobs_done
);

  localparam int CNT_MAX = ((RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT) + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   cur_id_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              seen_low_q;
  logic [511:0]      core_data_q;
  logic              res_valid_q;
  logic              res_err_q;
  logic [ID_W-1:0]   res_id_q;
  logic [255:0]      res_hash_q;
  logic [15:0]       jobs_done_q;

  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   rr_ptr_d;
  logic              any_valid;
  logic              grant;
  logic [511:0]      slot [N_REQ];

  // Search downward in offset so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    int idx;
    logic [ID_W-1:0] idx_w;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = idx[ID_W-1:0];
      if (blk_valid[idx_w]) begin
        any_valid = 1'b1;
        winner    = idx_w;
      end
    end
  end

  assign rr_ptr_d = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
  assign grant    = (state_q == IDLE) && any_valid;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign slot[gi]      = blk_data[gi*512 +: 512];
    assign blk_ready[gi] = grant && (winner == ID_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      cnt_q       <= '0;
      seen_low_q  <= 1'b0;
      core_data_q <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_id_q    <= '0;
      res_hash_q  <= '0;
      jobs_done_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            core_data_q <= slot[winner];
            cur_id_q    <= winner;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= '0;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            cnt_q      <= '0;
            seen_low_q <= 1'b0;
            state_q    <= RUN;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          seen_low_q <= seen_low_q | ~core_ready;
          cnt_q      <= cnt_q + CNT_W'(1);
          // A ready that was never seen low belongs to the previous job and is ignored.
          if (core_ready && seen_low_q) begin
            res_hash_q  <= core_hash;
            res_err_q   <= 1'b0;
            res_id_q    <= cur_id_q;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            res_hash_q  <= '0;
            res_err_q   <= 1'b1;
            res_id_q    <= cur_id_q;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            jobs_done_q <= jobs_done_q + 16'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_reset = (state_q != RUN);
  assign core_data  = core_data_q;
  assign res_valid  = res_valid_q;
  assign res_err    = res_err_q;
  assign res_id     = res_id_q;
  assign res_hash   = res_hash_q;
  assign busy       = (state_q != IDLE);
  assign jobs_done  = jobs_done_q;

endmodule

// File: tb/tb_sha256_job_sched.sv
// Bench for sha256_job_sched: behavioural sha256 core stub plus an arithmetic SHA-256 reference
// and a round-robin grant model; random blocks, masks, core latencies and consumer delays.
module tb_sha256_job_sched;
  localparam int N_REQ      = 4;
  localparam int ID_W       = 2;
  localparam int RST_CYCLES = 3;
  localparam int TIMEOUT    = 255;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N_REQ-1:0] blk_valid = '0;
  logic [N_REQ*512-1:0] blk_data = '0;
  logic [N_REQ-1:0] blk_ready;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [ID_W-1:0] res_id;
  logic [255:0] res_hash;
  logic res_err;
  logic core_reset;
  logic [511:0] core_data;
  logic core_ready = 1'b1;
  logic [255:0] core_hash = {8{32'hdeadbeef}};
  logic busy;
  logic [15:0] jobs_done;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;
  int exp_jobs = 0;
  bit stuck = 1'b0;
  int lat_target = 4;
  int lat_cnt = 0;

  always #5 clk = ~clk;

  sha256_job_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_hash(res_hash), .res_err(res_err),
    .core_reset(core_reset), .core_data(core_data), .core_ready(core_ready), .core_hash(core_hash),
    .busy(busy), .jobs_done(jobs_done));

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_blk(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    a = 32'h6a09e667; b = 32'hbb67ae85; c = 32'h3c6ef372; d = 32'ha54ff53a;
    e = 32'h510e527f; f = 32'h9b05688c; g = 32'h1f83d9ab; h = 32'h5be0cd19;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {32'h6a09e667 + a, 32'hbb67ae85 + b, 32'h3c6ef372 + c, 32'ha54ff53a + d,
            32'h510e527f + e, 32'h9b05688c + f, 32'h1f83d9ab + g, 32'h5be0cd19 + h};
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int model_winner(input logic [N_REQ-1:0] v, input int ptr);
    for (int off = 0; off < N_REQ; off++)
      if (v[(ptr + off) % N_REQ]) return (ptr + off) % N_REQ;
    return -1;
  endfunction

  // Core stub: ready stays stale-high while in reset, drops once released, rises after a latency with the digest.
  always @(posedge clk) begin
    if (core_reset === 1'b1) begin
      core_ready <= 1'b1;
      lat_cnt    <= 0;
    end else if (stuck) begin
      core_ready <= 1'b1;
    end else if (lat_cnt < lat_target) begin
      core_ready <= 1'b0;
      lat_cnt    <= lat_cnt + 1;
    end else begin
      core_ready <= 1'b1;
      core_hash  <= sha256_blk(core_data);
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    blk_valid = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_ptr = 0;
    exp_jobs = 0;
  endtask

  task automatic wait_grant(output int gid, output bit ok);
    ok = 1'b0;
    gid = -1;
    for (int n = 0; n < 400; n++) begin
      #1;
      if (|blk_ready) begin
        ok = 1'b1;
        for (int i = 0; i < N_REQ; i++) if (blk_ready[i]) gid = i;
        if (!$onehot(blk_ready)) gid = -2;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({busy, res_valid, res_err, res_id, res_hash, core_reset, core_data, jobs_done, blk_ready} !==
        {1'b0, 1'b0, 1'b0, {ID_W{1'b0}}, 256'h0, 1'b1, 512'h0, 16'h0, {N_REQ{1'b0}}})
      begin errors++; $display("FAIL reset_state busy=%b rv=%b err=%b id=%0d core_reset=%b jobs=%0d rdy=%b",
        busy, res_valid, res_err, res_id, core_reset, jobs_done, blk_ready); end
  endtask

  task automatic test_abc();
    logic [511:0] blk;
    int gid;
    bit ok;
    blk = {32'h61626380, 448'h0, 32'h00000018};
    blk_data[0 +: 512] = blk;
    blk_valid = 4'b0001;
    lat_target = 5;
    wait_grant(gid, ok);
    checks++;
    if (gid !== 0) begin errors++; $display("FAIL abc_grant got %0d want 0", gid); end
    @(negedge clk);
    blk_valid = '0;
    checks++;
    if (core_data !== blk) begin errors++; $display("FAIL abc_core_data got %h want %h", core_data, blk); end
    wait_result(ok);
    checks++;
    if ({ok, res_id, res_err, res_hash} !==
        {1'b1, 2'd0, 1'b0, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad})
      begin errors++; $display("FAIL abc_result ok=%b id=%0d err=%b hash=%h", ok, res_id, res_err, res_hash); end
    $display("job abc id=%0d err=%0d hash=%h", res_id, res_err, res_hash);
    accept_result();
    exp_ptr = 1;
    exp_jobs++;
    checks++;
    if (jobs_done !== 16'(exp_jobs)) begin errors++; $display("FAIL abc_jobs_done got %0d want %0d", jobs_done, exp_jobs); end
  endtask

  task automatic test_round_robin();
    int gid, exp_id;
    bit ok;
    logic [511:0] blk;
    apply_reset();
    for (int i = 0; i < N_REQ; i++) blk_data[i*512 +: 512] = rand_blk();
    blk_valid = '1;
    for (int j = 0; j < 5; j++) begin
      wait_grant(gid, ok);
      exp_id = model_winner(blk_valid, exp_ptr);
      checks++;
      if (gid !== exp_id) begin errors++; $display("FAIL rr_grant job %0d got %0d want %0d", j, gid, exp_id); end
      blk = blk_data[exp_id*512 +: 512];
      exp_ptr = (exp_id + 1) % N_REQ;
      lat_target = $urandom_range(1, 12);
      @(negedge clk);
      blk_data[exp_id*512 +: 512] = rand_blk();
      wait_result(ok);
      checks++;
      if ({ok, res_id, res_err, res_hash} !== {1'b1, ID_W'(exp_id), 1'b0, sha256_blk(blk)})
        begin errors++; $display("FAIL rr_result job %0d ok=%b id=%0d err=%b hash=%h want %h",
          j, ok, res_id, res_err, res_hash, sha256_blk(blk)); end
      $display("job rr id=%0d err=%0d hash=%h", res_id, res_err, res_hash);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept_result();
      exp_jobs++;
      checks++;
      if (jobs_done !== 16'(exp_jobs)) begin errors++; $display("FAIL rr_jobs_done got %0d want %0d", jobs_done, exp_jobs); end
    end
    blk_valid = '0;
  endtask

  task automatic test_random_masks();
    int gid, exp_id;
    bit ok;
    logic [511:0] blk;
    logic [N_REQ-1:0] m;
    for (int j = 0; j < 10; j++) begin
      m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      for (int i = 0; i < N_REQ; i++) blk_data[i*512 +: 512] = rand_blk();
      blk_valid = m;
      wait_grant(gid, ok);
      exp_id = model_winner(m, exp_ptr);
      checks++;
      if (gid !== exp_id) begin errors++; $display("FAIL mask_grant mask=%b got %0d want %0d", m, gid, exp_id); end
      blk = blk_data[exp_id*512 +: 512];
      exp_ptr = (exp_id + 1) % N_REQ;
      lat_target = $urandom_range(1, 20);
      @(negedge clk);
      blk_valid = '0;
      wait_result(ok);
      checks++;
      if ({ok, res_id, res_err, res_hash} !== {1'b1, ID_W'(exp_id), 1'b0, sha256_blk(blk)})
        begin errors++; $display("FAIL mask_result mask=%b ok=%b id=%0d err=%b hash=%h", m, ok, res_id, res_err, res_hash); end
      $display("job mask=%b id=%0d err=%0d hash=%h", m, res_id, res_err, res_hash);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      accept_result();
      exp_jobs++;
    end
    checks++;
    if (jobs_done !== 16'(exp_jobs)) begin errors++; $display("FAIL mask_jobs_done got %0d want %0d", jobs_done, exp_jobs); end
  endtask

  task automatic test_backpressure();
    int gid, exp_id;
    bit ok, stable, no_grant;
    logic [511:0] blk;
    logic [ID_W+256:0] snap;
    for (int i = 0; i < N_REQ; i++) blk_data[i*512 +: 512] = rand_blk();
    blk_valid = '1;
    wait_grant(gid, ok);
    exp_id = model_winner(blk_valid, exp_ptr);
    checks++;
    if (gid !== exp_id) begin errors++; $display("FAIL bp_grant got %0d want %0d", gid, exp_id); end
    blk = blk_data[exp_id*512 +: 512];
    exp_ptr = (exp_id + 1) % N_REQ;
    lat_target = $urandom_range(1, 8);
    wait_result(ok);
    snap = {res_id, res_err, res_hash};
    checks++;
    if ({ok, snap} !== {1'b1, ID_W'(exp_id), 1'b0, sha256_blk(blk)})
      begin errors++; $display("FAIL bp_result ok=%b id=%0d err=%b hash=%h", ok, res_id, res_err, res_hash); end
    stable = 1'b1;
    no_grant = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      if (res_valid !== 1'b1 || {res_id, res_err, res_hash} !== snap) stable = 1'b0;
      if (blk_ready !== '0) no_grant = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL bp_stable got unstable res_* want held for 20 cycles"); end
    checks++;
    if (!no_grant) begin errors++; $display("FAIL bp_no_grant got blk_ready pulse want none in DONE"); end
    $display("job bp id=%0d err=%0d hash=%h", res_id, res_err, res_hash);
    accept_result();
    blk_valid = '0;
    exp_jobs++;
    checks++;
    if ({jobs_done, res_valid} !== {16'(exp_jobs), 1'b0})
      begin errors++; $display("FAIL bp_accept jobs=%0d rv=%b want jobs=%0d rv=0", jobs_done, res_valid, exp_jobs); end
  endtask

  task automatic test_timeout();
    int gid, exp_id, n_load, n_run;
    bit ok;
    logic [N_REQ-1:0] m;
    stuck = 1'b1;
    m = N_REQ'(1 << $urandom_range(0, N_REQ - 1));
    blk_data = {N_REQ{rand_blk()}};
    blk_valid = m;
    wait_grant(gid, ok);
    exp_id = model_winner(m, exp_ptr);
    checks++;
    if (gid !== exp_id) begin errors++; $display("FAIL to_grant got %0d want %0d", gid, exp_id); end
    exp_ptr = (exp_id + 1) % N_REQ;
    n_load = 0;
    n_run = 0;
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      blk_valid = '0;
      if (res_valid === 1'b1) begin ok = 1'b1; break; end
      if (core_reset === 1'b1) n_load++;
      else n_run++;
    end
    checks++;
    if (n_load !== RST_CYCLES) begin errors++; $display("FAIL to_load_cycles got %0d want %0d", n_load, RST_CYCLES); end
    checks++;
    if (n_run !== TIMEOUT) begin errors++; $display("FAIL to_run_cycles got %0d want %0d", n_run, TIMEOUT); end
    checks++;
    if ({ok, res_id, res_err, res_hash} !== {1'b1, ID_W'(exp_id), 1'b1, 256'h0})
      begin errors++; $display("FAIL to_result ok=%b id=%0d err=%b hash=%h", ok, res_id, res_err, res_hash); end
    $display("job timeout id=%0d err=%0d hash=%h", res_id, res_err, res_hash);
    accept_result();
    exp_jobs++;
    stuck = 1'b0;
    #1;
    checks++;
    if ({busy, jobs_done} !== {1'b0, 16'(exp_jobs)})
      begin errors++; $display("FAIL to_idle busy=%b jobs=%0d want busy=0 jobs=%0d", busy, jobs_done, exp_jobs); end
  endtask

  task automatic test_reset_mid_run();
    int gid;
    bit ok, quiet;
    logic [511:0] blk;
    blk_data = {N_REQ{rand_blk()}};
    blk_valid = N_REQ'(1 << $urandom_range(0, N_REQ - 1));
    lat_target = 200;
    wait_grant(gid, ok);
    for (int n = 0; n < 20 && core_reset !== 1'b0; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++;
    if (core_reset !== 1'b0) begin errors++; $display("FAIL mid_in_run core_reset=%b want 0", core_reset); end
    blk_valid = '0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_ptr = 0;
    exp_jobs = 0;
    checks++;
    if ({busy, core_reset, res_valid, jobs_done} !== {1'b0, 1'b1, 1'b0, 16'h0})
      begin errors++; $display("FAIL mid_reset busy=%b core_reset=%b rv=%b jobs=%0d", busy, core_reset, res_valid, jobs_done); end
    quiet = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL mid_abandon got activity after reset want none"); end
    for (int i = 0; i < N_REQ; i++) blk_data[i*512 +: 512] = rand_blk();
    blk_valid = '1;
    lat_target = 3;
    wait_grant(gid, ok);
    checks++;
    if (gid !== 0) begin errors++; $display("FAIL mid_rr_ptr got grant %0d want 0", gid); end
    blk = blk_data[0 +: 512];
    exp_ptr = 1;
    @(negedge clk);
    blk_valid = '0;
    wait_result(ok);
    checks++;
    if ({ok, res_id, res_err, res_hash} !== {1'b1, ID_W'(0), 1'b0, sha256_blk(blk)})
      begin errors++; $display("FAIL mid_result ok=%b id=%0d err=%b hash=%h", ok, res_id, res_err, res_hash); end
    $display("job after_reset id=%0d err=%0d hash=%h", res_id, res_err, res_hash);
    accept_result();
    exp_jobs++;
  endtask

  task automatic test_jobs_wrap();
    int gid;
    bit ok;
    blk_valid = '0;
    force dut.jobs_done_q = 16'hFFFF;
    @(negedge clk);
    release dut.jobs_done_q;
    #1;
    checks++;
    if (jobs_done !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h want ffff", jobs_done); end
    blk_data = {N_REQ{rand_blk()}};
    blk_valid = '1;
    lat_target = 2;
    wait_grant(gid, ok);
    @(negedge clk);
    blk_valid = '0;
    wait_result(ok);
    $display("job wrap id=%0d err=%0d hash=%h", res_id, res_err, res_hash);
    accept_result();
    checks++;
    if ({ok, jobs_done} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL wrap_jobs_done ok=%b got %h want 0000", ok, jobs_done); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_round_robin();
    test_random_masks();
    test_backpressure();
    test_timeout();
    test_reset_mid_run();
    test_jobs_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
